// File: rtl/ghr_spec_ctrl.sv
// Speculative/committed global-history controller with an in-order FIFO of
// predicted directions, mispredict repair and a fixed post-repair stall.
module ghr_spec_ctrl #(
    parameter int M           = 4,
    parameter int DEPTH       = 4,
    parameter int RECOVER_CYC = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic [M-1:0]               spec_hist,
    output logic [M-1:0]               commit_hist,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic                       mispredict,
    output logic                       res_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(RECOVER_CYC) + 1;

    typedef enum logic [0:0] {RUN, RECOVER} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [M-1:0]    spec_q, spec_d;
    logic [M-1:0]    commit_q, commit_d;
    logic            mis_q, mis_d;
    logic            err_q, err_d;

    logic            res_fire;
    logic            mis_now;
    logic            pred_fire;
    logic [M-1:0]    commit_shifted;

    // A resolve only counts against a non-empty FIFO; the head is the oldest prediction.
    assign res_fire       = res_valid & (count_q != '0);
    assign mis_now        = res_fire & (res_taken != fifo_q[rd_ptr_q]);
    assign commit_shifted = {commit_q[M-2:0], res_taken};

    always_comb begin
        pred_ready = 1'b0;
        if (!reset && state_q == RUN) begin
            pred_ready = (count_q < CW'(DEPTH)) & ~mis_now;
        end
    end

    assign pred_fire = pred_valid & pred_ready;

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        spec_d   = spec_q;
        commit_d = commit_q;
        mis_d    = mis_now;
        err_d    = res_valid & (count_q == '0);

        if (state_q == RECOVER) begin
            if (rcnt_q == '0) begin
                state_d = RUN;
            end else begin
                rcnt_d = rcnt_q - 1'b1;
            end
        end

        if (mis_now) begin
            // Repair: speculative history restarts from the corrected committed one.
            commit_d = commit_shifted;
            spec_d   = commit_shifted;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = RECOVER;
            rcnt_d   = RW'(RECOVER_CYC - 1);
        end else begin
            if (res_fire) begin
                commit_d = commit_shifted;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (pred_fire) begin
                fifo_d[wr_ptr_q] = pred_taken;
                wr_ptr_d         = wr_ptr_q + 1'b1;
                spec_d           = {spec_q[M-2:0], pred_taken};
            end
            if (pred_fire && !res_fire) begin
                count_d = count_q + 1'b1;
            end else if (res_fire && !pred_fire) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            rcnt_q   <= '0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            spec_q   <= '0;
            commit_q <= '0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            spec_q   <= spec_d;
            commit_q <= commit_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
        end
    end

    assign spec_hist   = spec_q;
    assign commit_hist = commit_q;
    assign inflight    = count_q;
    assign mispredict  = mis_q;
    assign res_err     = err_q;
endmodule
